// File: rtl/frame_buffer_ctrl.sv
// Ping-pong frame-buffer write controller: captures one VSYNC-delimited frame into the back bank
// and swaps banks on a complete frame once the consumer has released the front bank.
module frame_buffer_ctrl #(
  parameter  int RESOLUTION_WIDTH  = 640,
  parameter  int RESOLUTION_HEIGHT = 480,
  localparam int NPIX              = RESOLUTION_WIDTH * RESOLUTION_HEIGHT,
  localparam int AW                = $clog2(NPIX)
) (
  input  logic          PCLK,
  input  logic          RST_N,
  input  logic          VSYNC,
  input  logic          DV,
  input  logic [15:0]   i_pixel,
  input  logic [AW-1:0] i_w_addr,
  input  logic          i_enable,
  input  logic          i_release,
  output logic          o_wr_en,
  output logic [AW:0]   o_wr_addr,
  output logic [15:0]   o_wr_data,
  output logic          o_rd_bank,
  output logic          o_rd_busy,
  output logic          o_frame_ready,
  output logic          o_frame_drop,
  output logic          o_frame_err,
  output logic [15:0]   o_frame_count
);

  localparam int CW = $clog2(NPIX + 1);
  localparam logic [AW:0]   NPIX_A = (AW + 1)'(NPIX);
  localparam logic [CW-1:0] NPIX_C = CW'(NPIX);

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_WAIT_START = 2'd1;
  localparam logic [1:0] ST_CAPTURE    = 2'd2;
  localparam logic [1:0] ST_COMMIT     = 2'd3;

  logic [1:0]    state;
  logic          vs_q;
  logic          wr_bank;
  logic          err_flag;
  logic [CW-1:0] pix_cnt;

  logic frame_start;
  logic frame_end;
  logic addr_ok;
  logic cnt_ok;

  always_comb begin
    frame_start = vs_q & ~VSYNC;
    frame_end   = ~vs_q & VSYNC;
    addr_ok     = {1'b0, i_w_addr} < NPIX_A;
    cnt_ok      = pix_cnt < NPIX_C;
  end

  always_ff @(posedge PCLK or negedge RST_N) begin
    if (!RST_N) begin
      state         <= ST_IDLE;
      vs_q          <= 1'b0;
      wr_bank       <= 1'b0;
      err_flag      <= 1'b0;
      pix_cnt       <= '0;
      o_wr_en       <= 1'b0;
      o_wr_addr     <= '0;
      o_wr_data     <= '0;
      o_rd_bank     <= 1'b1;
      o_rd_busy     <= 1'b0;
      o_frame_ready <= 1'b0;
      o_frame_drop  <= 1'b0;
      o_frame_err   <= 1'b0;
      o_frame_count <= '0;
    end else begin
      vs_q          <= VSYNC;
      o_wr_en       <= 1'b0;
      o_frame_ready <= 1'b0;
      o_frame_drop  <= 1'b0;
      o_frame_err   <= 1'b0;

      // A release is applied before the commit decision, so it may free the bank for this swap
      if (i_release) o_rd_busy <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (i_enable) state <= ST_WAIT_START;
        end
        ST_WAIT_START: begin
          if (!i_enable) begin
            state <= ST_IDLE;
          end else if (frame_start) begin
            state    <= ST_CAPTURE;
            pix_cnt  <= '0;
            err_flag <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          if (!i_enable) begin
            state <= ST_IDLE;
          end else begin
            if (DV) begin
              if (addr_ok && cnt_ok) begin
                o_wr_en   <= 1'b1;
                o_wr_addr <= {wr_bank, i_w_addr};
                o_wr_data <= i_pixel;
                pix_cnt   <= pix_cnt + CW'(1);
              end else begin
                err_flag <= 1'b1;
              end
            end
            if (frame_end) state <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          if (err_flag || (pix_cnt != NPIX_C)) begin
            o_frame_err <= 1'b1;
          end else if (o_rd_busy && !i_release) begin
            o_frame_drop <= 1'b1;
          end else begin
            wr_bank       <= ~wr_bank;
            o_rd_bank     <= wr_bank;
            o_rd_busy     <= 1'b1;
            o_frame_ready <= 1'b1;
            o_frame_count <= o_frame_count + 16'd1;
          end
          state <= i_enable ? ST_WAIT_START : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
